// File: rtl/pair_index_generator_cofactor.sv
// Cofactor index producer: buffers a basis-state list, then for each entry finds
// the first partner (basis ^ toggle_mask) and writes {pair_valid, position} to the index FIFO.
module pair_index_generator_cofactor #(
    parameter int num_qubit = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [num_qubit-1:0] basis_in,
    input  logic                 basis_valid,
    input  logic                 basis_last,
    input  logic [num_qubit-1:0] toggle_mask,
    output logic                 basis_ready,
    input  logic                 index_fifo_full,
    output logic                 index_write,
    output logic [num_qubit:0]   index_out,
    output logic [31:0]          counter_vector,
    output logic                 busy,
    output logic                 done
);
    localparam int N  = 1 << num_qubit;
    localparam int CW = num_qubit + 1;

    typedef enum logic [1:0] {IDLE, SEARCH, PUSH, DONE} state_t;

    state_t                 state, state_nx;
    logic [num_qubit-1:0]   mem [N];
    logic [CW-1:0]          count, count_inc, last_pos;
    logic [num_qubit-1:0]   i, j, idx, mask_q, target;
    logic                   found;
    logic                   accept, hit, j_end, i_end;

    assign accept    = (state == IDLE) && basis_valid && (count < CW'(N));
    assign count_inc = count + CW'(accept);
    assign last_pos  = count - CW'(1);
    assign target    = mem[i] ^ mask_q;
    // Self-compare excluded so a zero mask only pairs genuine duplicates
    assign hit       = (j != i) && (mem[j] == target);
    assign j_end     = ({1'b0, j} == last_pos);
    assign i_end     = ({1'b0, i} == last_pos);

    assign basis_ready = (state == IDLE) && (count < CW'(N));
    assign index_write = (state == PUSH) && !index_fifo_full;
    assign index_out   = {found, idx};
    assign busy        = (state == SEARCH) || (state == PUSH);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (basis_last) state_nx = (count_inc == '0) ? DONE : SEARCH;
            SEARCH: if (hit || j_end) state_nx = PUSH;
            PUSH:   if (!index_fifo_full) state_nx = i_end ? DONE : SEARCH;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage needs no reset; count gates which entries are meaningful
    always_ff @(posedge clk) begin
        if (accept) mem[count[num_qubit-1:0]] <= basis_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count          <= '0;
            i              <= '0;
            j              <= '0;
            found          <= 1'b0;
            idx            <= '0;
            mask_q         <= '0;
            counter_vector <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= count_inc;
                    if (basis_last) begin
                        mask_q         <= toggle_mask;
                        counter_vector <= 32'(count_inc);
                        i              <= '0;
                        j              <= '0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        found <= 1'b1;
                        idx   <= j;
                    end else if (j_end) begin
                        found <= 1'b0;
                        idx   <= '0;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                PUSH: begin
                    if (index_write && !i_end) begin
                        i <= i + 1'b1;
                        j <= '0;
                    end
                end
                DONE: count <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pair_index_generator_cofactor.md
Name: pair_index_generator_cofactor

Overview:
- Producer side of the cofactor index FIFO. Collects the basis-state list of the current phase vector.
- For each entry, searches for the partner state (basis XOR toggle_mask). Writes one {pair_valid, pair_position} word per entry into the index FIFO.
- Publishes the entry count as counter_vector for the downstream address generator, which pops those words.

Parameters:
num_qubit, 3, basis-state width; storage depth N = 2^num_qubit entries

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (0 = reset)
basis_in  input  num_qubit  basis state of the next entry
basis_valid  input  1  basis_in valid; accepted when basis_ready=1
basis_last  input  1  end of list; may coincide with basis_valid
toggle_mask  input  num_qubit  qubit toggle pattern; sampled on the basis_last cycle
basis_ready  output  1  block can accept a basis entry
index_fifo_full  input  1  index FIFO cannot accept a write
index_write  output  1  FIFO write enable
index_out  output  num_qubit+1  [num_qubit]=pair exists, [num_qubit-1:0]=partner position (0 if none)
counter_vector  output  32  number of entries in the current list
busy  output  1  high in SEARCH or PUSH
done  output  1  one-cycle pulse after the last FIFO write

Behaviour:
- Reset (rst=0, async): state=IDLE; count, i, j, found, idx = 0; counter_vector=0. All outputs 0 except basis_ready=1. Any write in flight is dropped; index_write goes low immediately.
- Storage: N x num_qubit register array. count is num_qubit+1 bits wide.
- IDLE:
  - basis_ready = (count < N).
  - basis_valid & basis_ready: mem[count] <= basis_in; count++.
  - basis_valid while count==N: entry ignored, no overflow wrap.
  - basis_last: latch toggle_mask; counter_vector <= final count, including a same-cycle accepted entry.
  - If the final count is 0: go to DONE.
  - Otherwise: i=0, j=0, go to SEARCH.
- SEARCH (one compare per cycle):
  - target = mem[i] ^ mask_q.
  - If j != i and mem[j] == target: found=1, idx=j, go to PUSH. The first (lowest j) match wins.
  - Else if j == count-1: found=0, idx=0, go to PUSH.
  - Else: j++.
  - Self-compare is excluded, so mask 0 yields no pair unless the list holds duplicate states.
- PUSH:
  - index_out = {found, idx}; index_write = ~index_fifo_full (combinational).
  - While full: hold state, index_out stable, no write.
  - On write: if i == count-1 go to DONE; else i++, j=0, go to SEARCH.
- DONE: done=1 for one cycle; count <= 0; go to IDLE.
- counter_vector:
  - Updated only on basis_last.
  - Stable through SEARCH/PUSH/DONE and the following IDLE until the next basis_last, so the consumer can sample it when the FIFO first becomes non-empty.
- Ordering: exactly counter_vector FIFO words per list, in entry order 0..count-1.
- basis_ready=0 in SEARCH, PUSH and DONE; basis_valid and basis_last are ignored there.
- Latency per entry: (j cycles until match or count-1) + 1 SEARCH cycle + >=1 PUSH cycle. First write occurs no earlier than 2 cycles after basis_last.

Test Plan:
1. Load 000,001,010,011, toggle_mask=001, last with the 4th -> writes 4'b1001, 4'b1000, 4'b1011, 4'b1010 in order; counter_vector=4; one done pulse.
2. Load 000,011, mask=001 -> writes 4'b0000, 4'b0000; counter_vector=2.
3. Scenario 1 with index_fifo_full=1 for 5 cycles at the first PUSH -> index_write=0 and index_out=4'b1001 held for those cycles; no word lost or duplicated; order unchanged.
4. Load 8 entries then a 9th basis_valid -> basis_ready=0 after the 8th, 9th ignored; counter_vector=8; 8 writes.
5. basis_last with no entries -> done one cycle later, zero writes, counter_vector=0, basis_ready=1 afterwards.
6. rst=0 mid-SEARCH of scenario 1 -> index_write, busy, counter_vector at 0 immediately. After release, rerunning scenario 2 gives the correct results.
